// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_unit_pkg
//  Brief    : Shared constants for the writeback stage (result sources and
//             load width codes).
//  Revision : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

   // Result source selected by the retiring instruction
   localparam logic [1:0] WB_TYPE_NONE = 2'd0;
   localparam logic [1:0] WB_TYPE_ALU  = 2'd1;
   localparam logic [1:0] WB_TYPE_MEM  = 2'd2;
   localparam logic [1:0] WB_TYPE_PC4  = 2'd3;

   // Load width codes (funct3 field of the load instruction)
   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_unit_if
//  Brief    : Retire handshake, data-memory response and register-file write
//             port of the writeback stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface writeback_unit_if;

   logic        in_valid;
   logic        in_ready;
   logic [1:0]  wb_type;
   logic [31:0] alu_result;
   logic [31:0] pc;
   logic [4:0]  rd;
   logic [2:0]  load_funct3;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        busy;
   logic        err;

   // Pipeline / memory side that feeds the writeback stage
   modport master (
      output in_valid, wb_type, alu_result, pc, rd, load_funct3,
             mem_rvalid, mem_rdata,
      input  in_ready, rf_we, rf_waddr, rf_wdata, busy, err
   );

   // The writeback stage itself
   modport slave (
      input  in_valid, wb_type, alu_result, pc, rd, load_funct3,
             mem_rvalid, mem_rdata,
      output in_ready, rf_we, rf_waddr, rf_wdata, busy, err
   );

endinterface
`default_nettype wire

// File: rtl/writeback_unit_load_extender.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_unit_load_extender
//  Brief    : Combinational byte/halfword/word extraction with sign or zero
//             extension, plus an illegal-width / misalignment flag.
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_unit_load_extender
   import writeback_unit_pkg::*;
(
   input  wire logic [31:0] i_word,
   input  wire logic [1:0]  i_addr_lo,
   input  wire logic [2:0]  i_funct3,
   output      logic [31:0] o_result,
   output      logic        o_bad
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane select from the aligned word, then extend according to the width code
   always_comb begin
      w_byte   = i_word[{i_addr_lo, 3'b000} +: 8];
      w_half   = i_word[{i_addr_lo[1], 4'b0000} +: 16];
      o_result = 32'd0;
      o_bad    = 1'b0;
      case (i_funct3)
         LOAD_LB:  o_result = {{24{w_byte[7]}}, w_byte};
         LOAD_LBU: o_result = {24'd0, w_byte};
         LOAD_LH: begin
            o_result = {{16{w_half[15]}}, w_half};
            o_bad    = i_addr_lo[0];
         end
         LOAD_LHU: begin
            o_result = {16'd0, w_half};
            o_bad    = i_addr_lo[0];
         end
         LOAD_LW: begin
            o_result = i_word;
            o_bad    = |i_addr_lo;
         end
         default:  o_bad = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_unit
//  Brief    : Writeback stage. ALU / link results retire in one cycle; loads
//             wait for the data-memory response, get extended and retire, or
//             are abandoned with err on misalignment, bad width or timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input wire logic       clk,
   input wire logic       rst_n,
   writeback_unit_if.slave bus
);

   localparam int unsigned          c_CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0]   c_LIMIT   = c_CNT_W'(TIMEOUT);
   localparam logic [c_CNT_W-1:0]   c_ONE     = c_CNT_W'(1);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_WAIT_MEM = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [4:0]         r_rd;
   logic [2:0]         r_funct3;
   logic [1:0]         r_addr_lo;

   logic               r_we;
   logic [4:0]         r_waddr;
   logic [31:0]        r_wdata;
   logic               r_err;

   logic               w_we_nxt;
   logic [4:0]         w_waddr_nxt;
   logic [31:0]        w_wdata_nxt;
   logic               w_err_nxt;

   logic               w_accept;
   logic               w_accept_mem;
   logic               w_at_limit;
   logic [1:0]         w_ext_lo;
   logic [2:0]         w_ext_f3;
   logic [31:0]        w_ext_result;
   logic               w_ext_bad;

   assign w_accept     = bus.in_valid && (r_state == S_IDLE);
   assign w_accept_mem = w_accept && (bus.wb_type == WB_TYPE_MEM);
   assign w_at_limit   = (r_cnt == c_LIMIT);

   // The extender checks legality of the incoming load while idle and formats
   // the captured load's data while waiting, so one instance serves both.
   assign w_ext_lo = (r_state == S_IDLE) ? bus.alu_result[1:0] : r_addr_lo;
   assign w_ext_f3 = (r_state == S_IDLE) ? bus.load_funct3      : r_funct3;

   writeback_unit_load_extender u_load_extender (
      .i_word    (bus.mem_rdata),
      .i_addr_lo (w_ext_lo),
      .i_funct3  (w_ext_f3),
      .o_result  (w_ext_result),
      .o_bad     (w_ext_bad)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: legal loads wait for memory until data or timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_accept_mem && !w_ext_bad) w_state_nxt = S_WAIT_MEM;
         S_WAIT_MEM: if (bus.mem_rvalid || w_at_limit) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs: handshake status plus the next values of the registered write port
   always_comb begin
      bus.in_ready = (r_state == S_IDLE);
      bus.busy     = (r_state == S_WAIT_MEM);
      w_we_nxt     = 1'b0;
      w_waddr_nxt  = r_waddr;
      w_wdata_nxt  = r_wdata;
      w_err_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (bus.wb_type)
                  WB_TYPE_ALU: if (bus.rd != 5'd0) begin
                     w_we_nxt    = 1'b1;
                     w_waddr_nxt = bus.rd;
                     w_wdata_nxt = bus.alu_result;
                  end
                  WB_TYPE_PC4: if (bus.rd != 5'd0) begin
                     w_we_nxt    = 1'b1;
                     w_waddr_nxt = bus.rd;
                     w_wdata_nxt = bus.pc + 32'd4;
                  end
                  WB_TYPE_MEM: w_err_nxt = w_ext_bad;
                  default:     w_we_nxt  = 1'b0;
               endcase
            end
         end
         S_WAIT_MEM: begin
            if (bus.mem_rvalid) begin
               if (r_rd != 5'd0) begin
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = r_rd;
                  w_wdata_nxt = w_ext_result;
               end
            end else if (w_at_limit) begin
               w_err_nxt = 1'b1;
            end
         end
         default: w_we_nxt = 1'b0;
      endcase
   end

   // Registered write port, load capture and timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we      <= 1'b0;
         r_waddr   <= 5'd0;
         r_wdata   <= 32'd0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
         r_rd      <= 5'd0;
         r_funct3  <= 3'd0;
         r_addr_lo <= 2'd0;
      end else begin
         r_we    <= w_we_nxt;
         r_waddr <= w_waddr_nxt;
         r_wdata <= w_wdata_nxt;
         r_err   <= w_err_nxt;
         if (w_accept_mem) begin
            r_rd      <= bus.rd;
            r_funct3  <= bus.load_funct3;
            r_addr_lo <= bus.alu_result[1:0];
            r_cnt     <= '0;
         end else if ((r_state == S_WAIT_MEM) && !bus.mem_rvalid && !w_at_limit) begin
            r_cnt <= r_cnt + c_ONE;
         end
      end
   end

   assign bus.rf_we    = r_we;
   assign bus.rf_waddr = r_waddr;
   assign bus.rf_wdata = r_wdata;
   assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_unit
//  Brief    : Scoreboard bench for writeback_unit: directed cases followed by
//             random retire traffic against a behavioural load/write model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;
   import writeback_unit_pkg::*;

   localparam int T = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      bit          is_err;
      logic [4:0]  addr;
      logic [31:0] data;
      int          when;
   } exp_t;

   exp_t sbq[$];

   writeback_unit_if bus();

   writeback_unit #(.TIMEOUT(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference rules for load legality and data formatting
   function automatic bit legal(input int f3, input int lo);
      case (f3)
         0, 4:    return 1'b1;
         1, 5:    return (lo % 2) == 0;
         2:       return lo == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_val(input int f3, input int lo, input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (8 * lo)) & 32'hFF;
      h = (word >> (16 * (lo / 2))) & 32'hFFFF;
      case (f3)
         0:       return (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
         4:       return b;
         1:       return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
         5:       return h;
         default: return word;
      endcase
   endfunction

   // Monitor: every write or err pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (bus.rf_we || bus.err)) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output we=%0b err=%0b addr=%0d data=%h required=none (cycle %0d)",
                     bus.rf_we, bus.err, bus.rf_waddr, bus.rf_wdata, cyc);
         end else begin
            e = sbq.pop_front();
            check("err_pulse", 32'(bus.err), 32'(e.is_err));
            check("rf_we", 32'(bus.rf_we), 32'(!e.is_err));
            check("out_cycle", 32'(cyc), 32'(e.when));
            if (!e.is_err) begin
               check("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
               check("rf_wdata", bus.rf_wdata, e.data);
            end
         end
      end
   end

   task automatic scramble_idle_inputs();
      bus.wb_type     = 2'($urandom);
      bus.alu_result  = $urandom;
      bus.pc          = $urandom;
      bus.rd          = 5'($urandom);
      bus.load_funct3 = 3'($urandom);
      bus.mem_rdata   = $urandom;
   endtask

   // Present one instruction; for loads, also play the memory side.
   // d = idle WAIT_MEM cycles before rvalid; d > T means memory never answers.
   // rst_mid = pull reset two cycles into the wait instead.
   task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3, input int d,
                        input logic [31:0] word, input bit rst_mid);
      int a;
      int lo;
      bus.wb_type     = t;
      bus.rd          = rd;
      bus.alu_result  = alu;
      bus.pc          = pc;
      bus.load_funct3 = f3;
      bus.in_valid    = 1'b1;
      check("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      a = cyc;
      bus.in_valid = 1'b0;
      scramble_idle_inputs();
      lo = int'(alu[1:0]);
      case (t)
         WB_TYPE_ALU: if (rd != 0) sbq.push_back('{1'b0, rd, alu, a});
         WB_TYPE_PC4: if (rd != 0) sbq.push_back('{1'b0, rd, pc + 32'd4, a});
         WB_TYPE_MEM: begin
            if (!legal(int'(f3), lo)) begin
               sbq.push_back('{1'b1, 5'd0, 32'd0, a});
               check("busy_after_bad_load", 32'(bus.busy), 32'd0);
            end else if (rst_mid) begin
               repeat (2) @(posedge clk);
               #1;
               rst_n = 1'b0;
               #2;
               check("busy_in_reset", 32'(bus.busy), 32'd0);
               check("in_ready_in_reset", 32'(bus.in_ready), 32'd1);
               check("rf_we_in_reset", 32'(bus.rf_we), 32'd0);
               check("err_in_reset", 32'(bus.err), 32'd0);
               @(posedge clk);
               #1;
               rst_n = 1'b1;
               // a late memory answer after reset must be ignored
               bus.mem_rdata  = word;
               bus.mem_rvalid = 1'b1;
               @(posedge clk);
               #1;
               bus.mem_rvalid = 1'b0;
               check("busy_after_reset", 32'(bus.busy), 32'd0);
            end else if (d <= T) begin
               if (rd != 0) sbq.push_back('{1'b0, rd, load_val(int'(f3), lo, word), a + d + 1});
               repeat (d) begin
                  check("busy_wait", 32'(bus.busy), 32'd1);
                  check("in_ready_wait", 32'(bus.in_ready), 32'd0);
                  @(posedge clk);
                  #1;
               end
               check("busy_wait", 32'(bus.busy), 32'd1);
               bus.mem_rdata  = word;
               bus.mem_rvalid = 1'b1;
               @(posedge clk);
               #1;
               bus.mem_rvalid = 1'b0;
               check("busy_after_rvalid", 32'(bus.busy), 32'd0);
               check("in_ready_after_rvalid", 32'(bus.in_ready), 32'd1);
            end else begin
               sbq.push_back('{1'b1, 5'd0, 32'd0, a + T + 1});
               repeat (T + 1) begin
                  check("busy_timeout_wait", 32'(bus.busy), 32'd1);
                  @(posedge clk);
                  #1;
               end
               check("in_ready_after_timeout", 32'(bus.in_ready), 32'd1);
               // rvalid while idle must be ignored
               bus.mem_rdata  = word;
               bus.mem_rvalid = 1'b1;
               @(posedge clk);
               #1;
               bus.mem_rvalid = 1'b0;
            end
         end
         default: ;
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid   = 1'b0;
      bus.mem_rvalid = 1'b0;
      scramble_idle_inputs();
      #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rf_we", 32'(bus.rf_we), 32'd0);
      check("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
      check("reset_rf_wdata", bus.rf_wdata, 32'd0);
      check("reset_err", 32'(bus.err), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);

      // Directed cases
      issue(WB_TYPE_ALU, 5'd5, 32'hDEADBEEF, 32'h0, 3'd0, 0, 32'h0, 1'b0);
      issue(WB_TYPE_PC4, 5'd1, 32'h0, 32'h00000100, 3'd0, 0, 32'h0, 1'b0);
      issue(WB_TYPE_MEM, 5'd3, 32'h00001002, 32'h0, LOAD_LB,  2, 32'h12F45678, 1'b0);
      issue(WB_TYPE_MEM, 5'd7, 32'h00002002, 32'h0, LOAD_LHU, 0, 32'h8001ABCD, 1'b0);
      issue(WB_TYPE_MEM, 5'd9, 32'h00003000, 32'h0, LOAD_LW,  1, 32'hCAFEF00D, 1'b0);
      issue(WB_TYPE_MEM, 5'd4, 32'h00003001, 32'h0, LOAD_LW,  0, 32'h0, 1'b0);
      issue(WB_TYPE_MEM, 5'd4, 32'h00003000, 32'h0, 3'b111,   0, 32'h0, 1'b0);
      issue(WB_TYPE_MEM, 5'd6, 32'h00004000, 32'h0, LOAD_LW,  T + 1, 32'h11111111, 1'b0);
      issue(WB_TYPE_MEM, 5'd8, 32'h00005000, 32'h0, LOAD_LW,  0, 32'h22222222, 1'b1);
      issue(WB_TYPE_ALU, 5'd0, 32'h12345678, 32'h0, 3'd0, 0, 32'h0, 1'b0);
      issue(WB_TYPE_MEM, 5'd0, 32'h00006000, 32'h0, LOAD_LH,  1, 32'h0000FFFF, 1'b0);
      issue(WB_TYPE_NONE, 5'd10, 32'hFFFFFFFF, 32'h0, 3'd0, 0, 32'h0, 1'b0);

      // Random traffic
      for (int i = 0; i < 250; i++) begin
         logic [4:0] r;
         r = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
         issue(2'($urandom), r, $urandom, $urandom, 3'($urandom),
               int'($urandom_range(T + 1, 0)), $urandom, 1'b0);
         if ($urandom_range(3, 0) == 0) begin
            repeat (int'($urandom_range(2, 1))) @(posedge clk);
            #1;
         end
      end

      repeat (T + 4) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage at the far end of the operand path: it takes a retiring instruction's result source, selects and formats the value, and drives the register-file write port that the decode stage reads operands from. Load results are held in a small state machine that waits for the data-memory response, extracts the byte, halfword or word, and sign- or zero-extends it. ALU and link (pc+4) results retire with a fixed one-cycle latency and back-to-back throughput.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of cycles spent in WAIT_MEM before the load is abandoned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  retiring instruction present.
- in_ready  out  1  unit can accept this cycle.
- wb_type  in  2  result source: `WB_TYPE_NONE`, `WB_TYPE_ALU`, `WB_TYPE_MEM`, `WB_TYPE_PC4`.
- alu_result  in  32  ALU result; for loads this is the effective address.
- pc  in  32  instruction pc.
- rd  in  5  destination register.
- load_funct3  in  3  load width code: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  aligned 32-bit word from data memory.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- busy  out  1  high while in WAIT_MEM.
- err  out  1  one-cycle pulse on a misaligned load, an illegal funct3, or a timeout.

## Operation
- States: IDLE, WAIT_MEM.
- in_ready = (state == IDLE). An instruction is accepted when in_valid && in_ready.
- Accept, IDLE:
  - NONE, or rd == 0: no write.
  - ALU: data = alu_result.
  - PC4: data = pc + 32'd4, mod 2^32.
  - ALU or PC4 with rd != 0: write is registered and presented the next cycle. State stays IDLE.
  - MEM: capture rd, funct3 and addr_lo = alu_result[1:0]; check legality first (next bullet). If legal, go to WAIT_MEM and clear the timeout counter.
- Legality check on accepting a MEM:
  - Illegal funct3 (011, 110, 111), LH/LHU with addr_lo[0] = 1, or LW with addr_lo != 0 all raise err the next cycle.
  - No write, and the unit stays in IDLE.
- WAIT_MEM, when mem_rvalid = 1:
  - Select the byte at mem_rdata[8*addr_lo +: 8] or the halfword at mem_rdata[16*addr_lo[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - If rd != 0, write the result the next cycle. In all cases return to IDLE.
  - A load to rd == 0 still waits for mem_rvalid and then discards the data.
- WAIT_MEM, when mem_rvalid = 0: the counter increments. When the counter reaches TIMEOUT, pulse err, return to IDLE, and do not write.
- mem_rvalid is ignored while in IDLE.
- Reset while in WAIT_MEM: return to IDLE, drop the pending load, and produce no write and no err.
- wb_type values outside the defined set behave as NONE.

## Timing
- Reset values:
  - state = IDLE
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - err = 0, busy = 0
  - in_ready = 1 once reset is released.
- rf_we, rf_waddr, rf_wdata and err are registered. rf_we is high for exactly one cycle per write.
- ALU/PC4 latency: write visible in cycle N+1 for acceptance in cycle N. One instruction per cycle is sustained.
- Load latency: write visible one cycle after the mem_rvalid cycle.
- The earliest valid response is the cycle after acceptance. in_ready goes low in that cycle and returns high in the cycle after mem_rvalid.
- Timeout: err is asserted in the cycle after the count reaches TIMEOUT. Total time in WAIT_MEM is TIMEOUT+1 cycles.
- busy equals (state == WAIT_MEM), derived combinationally from the state register.

## Structure
- Add `WB_TYPE_NONE`=2'd0, `WB_TYPE_ALU`=2'd1, `WB_TYPE_MEM`=2'd2, `WB_TYPE_PC4`=2'd3 and the load funct3 codes to the shared define.vh, alongside the `OP_TYPE_*` constants.
- One natural sub-module, load_extender: purely combinational. Inputs are the word, addr_lo and funct3; outputs are the 32-bit result and an illegal/misaligned flag.
- The FSM and the timeout counter live in writeback_unit.

## Test plan
- Back-to-back ALU: ALU rd=5 0xDEADBEEF, then PC4 rd=1 pc=0x00000100 -> rf_we in two consecutive cycles; (5, 0xDEADBEEF), then (1, 0x00000104); in_ready stays 1.
- LB sign-extension: LB rd=3 addr_lo=2, mem_rdata=0x12F45678, rvalid 3 cycles later -> busy and !in_ready for 3 cycles; then write (3, 0xFFFFFFF4).
- LHU: LHU rd=7 addr_lo=2, rdata=0x8001ABCD -> (7, 0x00008001). LW addr_lo=0, rdata=0xCAFEF00D -> 0xCAFEF00D.
- Misaligned and illegal: LW addr_lo=1, then funct3=3'b111 -> err pulse for each, no rf_we, no WAIT_MEM.
- Timeout: MEM legal, rvalid never asserted, TIMEOUT=4 -> err after 5 WAIT_MEM cycles, in_ready=1 the following cycle, no write.
- Reset mid-load, and rd=0: assert rst_n=0 during WAIT_MEM -> IDLE, no write, no err; ALU rd=0 -> no rf_we.
